// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: two-requester register-file write-port arbiter.
// Requester A (ALU writeback) and requester B (load writeback) share one
// write port. Only one of them is accepted in a cycle. When both are valid,
// the priority toggles after each grant, so the two sides alternate. The
// accepted write appears on the wr_* outputs one cycle after it is accepted.
// Optional feature: define WB_ZERO_FILTER_EN to drop writes to register 0.
// Such a write is still accepted and still advances the priority, but it
// never raises wr_en.
module wb_port_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [4:0]        a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [4:0]        b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              stall,
  output logic              wr_en,
  output logic [4:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              sel,
  output logic              conflict
);

  typedef enum logic {PRI_A = 1'b0, PRI_B = 1'b1} pri_t;

  pri_t              pri;
  logic              grant_a, grant_b, xfer, take;
  logic [4:0]        acc_addr;
  logic [DATA_W-1:0] acc_data;

  // Grant decode: a side that is valid alone wins; on a tie the prioritised side wins.
  always_comb begin
    grant_a  = 1'b0;
    grant_b  = 1'b0;
    if (!rst && !stall) begin
      grant_a = a_valid && (!b_valid || pri == PRI_A);
      grant_b = b_valid && (!a_valid || pri == PRI_B);
    end
    xfer     = grant_a || grant_b;
    acc_addr = grant_b ? b_addr : a_addr;
    acc_data = grant_b ? b_data : a_data;
`ifdef WB_ZERO_FILTER_EN
    take     = xfer && (acc_addr != 5'd0);
`else
    take     = xfer;
`endif
    a_ready  = grant_a;
    b_ready  = grant_b;
  end

  // Priority FSM and registered write-port outputs.
  // Registered outputs hold their last value when nothing is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      pri      <= PRI_A;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      sel      <= 1'b0;
      conflict <= 1'b0;
    end else begin
      if (grant_a)      pri <= PRI_B;
      else if (grant_b) pri <= PRI_A;
      wr_en <= take;
      if (take) begin
        wr_addr <= acc_addr;
        wr_data <= acc_data;
        sel     <= grant_b;
      end
      // Same-address collision. The loser keeps its request pending.
      conflict <= a_valid && b_valid && (a_addr == b_addr) && !stall;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed table-driven bench for wb_port_arbiter, plus an alternation sequence.
module tb_wb_port_arbiter;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              a_valid, b_valid, stall;
  logic [4:0]        a_addr, b_addr;
  logic [DATA_W-1:0] a_data, b_data;
  logic              a_ready, b_ready, wr_en, sel, conflict;
  logic [4:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;

  wb_port_arbiter #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .stall(stall), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sel(sel), .conflict(conflict)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, av, bv, stall;
    logic [4:0]  aa, ba;
    logic [31:0] ad, bd;
    logic        ar, br;
    logic        wen, wsel, conf;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic r, input logic av, input logic [4:0] aa,
                              input logic [31:0] ad, input logic bv, input logic [4:0] ba,
                              input logic [31:0] bd, input logic st,
                              input logic ar, input logic br, input logic wen,
                              input logic [4:0] waddr, input logic [31:0] wdata,
                              input logic wsel, input logic conf);
    vec_t v;
    v.rst = r; v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd;
    v.stall = st; v.ar = ar; v.br = br; v.wen = wen; v.waddr = waddr;
    v.wdata = wdata; v.wsel = wsel; v.conf = conf;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    // rst av aa ad       bv ba bd       st | ar br wen waddr wdata     sel conf
    vecs.push_back(mk(1, 0, 0, 0,      0, 0, 0,      0,  0, 0, 0, 0, 0,      0, 0));
    vecs.push_back(mk(1, 1, 5, 'h1234, 0, 0, 0,      0,  0, 0, 0, 0, 0,      0, 0));
    vecs.push_back(mk(0, 1, 5, 'h1234, 0, 0, 0,      0,  1, 0, 1, 5, 'h1234, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,      0, 0, 0,      0,  0, 0, 0, 5, 'h1234, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,      1, 2, 'hBB,   0,  0, 1, 1, 2, 'hBB,   1, 0));
    // both valid continuously: A,B,A,B
    vecs.push_back(mk(0, 1, 3, 'hA3,   1, 7, 'hB7,   0,  1, 0, 1, 3, 'hA3,   0, 0));
    vecs.push_back(mk(0, 1, 3, 'hA3,   1, 7, 'hB7,   0,  0, 1, 1, 7, 'hB7,   1, 0));
    vecs.push_back(mk(0, 1, 3, 'hA3,   1, 7, 'hB7,   0,  1, 0, 1, 3, 'hA3,   0, 0));
    vecs.push_back(mk(0, 1, 3, 'hA3,   1, 7, 'hB7,   0,  0, 1, 1, 7, 'hB7,   1, 0));
    // stall three cycles, then A wins
    vecs.push_back(mk(0, 1, 3, 'hA3,   1, 7, 'hB7,   1,  0, 0, 0, 7, 'hB7,   1, 0));
    vecs.push_back(mk(0, 1, 3, 'hA3,   1, 7, 'hB7,   1,  0, 0, 0, 7, 'hB7,   1, 0));
    vecs.push_back(mk(0, 1, 3, 'hA3,   1, 7, 'hB7,   1,  0, 0, 0, 7, 'hB7,   1, 0));
    vecs.push_back(mk(0, 1, 3, 'hA3,   1, 7, 'hB7,   0,  1, 0, 1, 3, 'hA3,   0, 0));
    vecs.push_back(mk(0, 0, 0, 0,      1, 7, 'hB7,   0,  0, 1, 1, 7, 'hB7,   1, 0));
    // same-address conflict
    vecs.push_back(mk(0, 1, 9, 'h91,   1, 9, 'h92,   0,  1, 0, 1, 9, 'h91,   0, 1));
    vecs.push_back(mk(0, 0, 0, 0,      1, 9, 'h92,   0,  0, 1, 1, 9, 'h92,   1, 0));
    // conflict masked by stall, then seen
    vecs.push_back(mk(0, 1, 4, 'h41,   1, 4, 'h42,   1,  0, 0, 0, 9, 'h92,   1, 0));
    vecs.push_back(mk(0, 1, 4, 'h41,   1, 4, 'h42,   0,  1, 0, 1, 4, 'h41,   0, 1));
    vecs.push_back(mk(0, 0, 0, 0,      1, 4, 'h42,   0,  0, 1, 1, 4, 'h42,   1, 0));
    // write to register 0
`ifdef WB_ZERO_FILTER_EN
    vecs.push_back(mk(0, 0, 0, 0,      1, 0, 'hFF,   0,  0, 1, 0, 4, 'h42,   1, 0));
    vecs.push_back(mk(0, 0, 0, 0,      0, 0, 0,      0,  0, 0, 0, 4, 'h42,   1, 0));
`else
    vecs.push_back(mk(0, 0, 0, 0,      1, 0, 'hFF,   0,  0, 1, 1, 0, 'hFF,   1, 0));
    vecs.push_back(mk(0, 0, 0, 0,      0, 0, 0,      0,  0, 0, 0, 0, 'hFF,   1, 0));
`endif
    // reset right after a transfer, then priority back at A
    vecs.push_back(mk(0, 1, 6, 'h66,   0, 0, 0,      0,  1, 0, 1, 6, 'h66,   0, 0));
    vecs.push_back(mk(1, 0, 0, 0,      1, 8, 'h88,   0,  0, 0, 0, 0, 0,      0, 0));
    vecs.push_back(mk(0, 1, 1, 'h11,   1, 8, 'h88,   0,  1, 0, 1, 1, 'h11,   0, 0));
    vecs.push_back(mk(0, 0, 0, 0,      1, 8, 'h88,   0,  0, 1, 1, 8, 'h88,   1, 0));
    vecs.push_back(mk(0, 0, 0, 0,      0, 0, 0,      0,  0, 0, 0, 8, 'h88,   1, 0));

    rst = 1; a_valid = 0; b_valid = 0; stall = 0;
    a_addr = 0; b_addr = 0; a_data = 0; b_data = 0;

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; stall = vecs[i].stall;
      a_valid = vecs[i].av; a_addr = vecs[i].aa; a_data = vecs[i].ad;
      b_valid = vecs[i].bv; b_addr = vecs[i].ba; b_data = vecs[i].bd;
      #1;
      chk("a_ready", i, 32'(a_ready), 32'(vecs[i].ar));
      chk("b_ready", i, 32'(b_ready), 32'(vecs[i].br));
      @(posedge clk); #1;
      chk("wr_en",    i, 32'(wr_en),    32'(vecs[i].wen));
      chk("wr_addr",  i, 32'(wr_addr),  32'(vecs[i].waddr));
      chk("wr_data",  i, wr_data,       vecs[i].wdata);
      chk("sel",      i, 32'(sel),      32'(vecs[i].wsel));
      chk("conflict", i, 32'(conflict), 32'(vecs[i].conf));
      n_vec++;
    end

    // Hand sequence: long continuous contention alternates strictly, starting with A.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      rst = 0; stall = 0;
      a_valid = 1; a_addr = 5'd10; a_data = 32'hA000 + k;
      b_valid = 1; b_addr = 5'd11; b_data = 32'hB000 + k;
      #1;
      chk("alt_a_ready", 100 + k, 32'(a_ready), 32'(k % 2 == 0));
      chk("alt_b_ready", 100 + k, 32'(b_ready), 32'(k % 2 == 1));
      @(posedge clk); #1;
      chk("alt_wr_en",   100 + k, 32'(wr_en),   32'd1);
      chk("alt_sel",     100 + k, 32'(sel),     32'(k % 2));
      chk("alt_wr_addr", 100 + k, 32'(wr_addr), (k % 2 == 0) ? 32'd10 : 32'd11);
      chk("alt_wr_data", 100 + k, wr_data, (k % 2 == 0) ? 32'hA000 + k : 32'hB000 + k);
      n_vec++;
    end

    @(negedge clk);
    a_valid = 0; b_valid = 0;
    @(posedge clk); #1;
    chk("idle_wr_en", 200, 32'(wr_en), 32'd0);
    chk("idle_hold_addr", 200, 32'(wr_addr), 32'd11);
    n_vec++;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, write-data width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 a_valid  input  1  requester A (ALU writeback) has a write pending.
REQ-005 a_addr  input  5  requester A destination register.
REQ-006 a_data  input  DATA_W  requester A write data.
REQ-007 a_ready  output  1  arbiter accepts A this cycle.
REQ-008 b_valid  input  1  requester B (load writeback) has a write pending.
REQ-009 b_addr  input  5  requester B destination register.
REQ-010 b_data  input  DATA_W  requester B write data.
REQ-011 b_ready  output  1  arbiter accepts B this cycle.
REQ-012 stall  input  1  register-file write port unavailable; block all acceptance.
REQ-013 wr_en  output  1  register-file write enable.
REQ-014 wr_addr  output  5  register-file write address.
REQ-015 wr_data  output  DATA_W  register-file write data.
REQ-016 sel  output  1  destination-mux select of the accepted write: 0 = A, 1 = B.
REQ-017 conflict  output  1  one-cycle pulse when both requesters were valid with equal addresses in the same cycle.

Function
REQ-018 Transfer on a requester occurs when its valid and ready are both 1 at a rising edge.
REQ-019 a_ready/b_ready are combinational from valid inputs, stall and priority state; at most one is 1 in any cycle.
REQ-020 Priority FSM states PRI_A and PRI_B: only A valid -> grant A; only B valid -> grant B; both valid -> grant the prioritised side.
REQ-021 Transition after a transfer: grant A -> PRI_B; grant B -> PRI_A; no transfer -> state held.
REQ-022 stall=1 -> a_ready=b_ready=0, FSM held, no transfer.
REQ-023 Outputs registered: accepted addr/data/sel appear on wr_addr/wr_data/sel with wr_en=1 exactly one cycle after the transfer edge (latency 1).
REQ-024 No transfer in a cycle -> wr_en=0 next cycle; wr_addr, wr_data, sel hold last values.
REQ-025 Back-to-back transfers every cycle supported; both valid continuously -> strict alternation A,B,A,B...
REQ-026 conflict registered with the same latency as wr_en; asserted when a_valid, b_valid both 1, a_addr==b_addr, stall=0; the losing request stays pending.
REQ-027 Requesters hold valid, addr, data stable until accepted; arbiter never drops a pending request.

Reset
REQ-028 rst=1 at an edge: FSM -> PRI_A; wr_en=0, wr_addr=0, wr_data=0, sel=0, conflict=0.
REQ-029 While rst=1, a_ready=b_ready=0; no transfer in that cycle.
REQ-030 Reset mid-stream discards any in-flight registered write (wr_en=0 in the next cycle).

Configuration
REQ-031 Macro WB_ZERO_FILTER_EN defined: a transfer with addr==0 is accepted (ready, FSM advances) but produces wr_en=0 next cycle; wr_addr/wr_data/sel still hold previous values.
REQ-032 WB_ZERO_FILTER_EN undefined: writes to address 0 pass through like any other address.

Verification
REQ-033 Reset, then a_valid=1, a_addr=5, a_data=0x1234 one cycle -> a_ready=1; next cycle wr_en=1, wr_addr=5, wr_data=0x1234, sel=0; following cycle wr_en=0.
REQ-034 a_valid=b_valid=1 held 4 cycles (addrs 3, 7) -> grants A,B,A,B; sel sequence 0,1,0,1 one cycle delayed; wr_addr 3,7,3,7.
REQ-035 Both valid, stall=1 for 3 cycles then 0 -> no ready, wr_en=0 for those cycles; first grant after stall goes to A (state held at PRI_A).
REQ-036 a_addr=b_addr=9 both valid -> conflict=1 for one cycle aligned with A's wr_en; B written next cycle, conflict=0.
REQ-037 b_valid=1, b_addr=0, b_data=0xFF -> with WB_ZERO_FILTER_EN: b_ready=1, wr_en stays 0; without: wr_en=1, wr_addr=0, sel=1.
REQ-038 Transfer accepted, rst=1 on the following edge -> wr_en=0, all outputs zero, FSM at PRI_A.
